ucaspian_link_mux: RTL and testbench

UCASPIAN_LINK_MUX -- requirements
Module: ucaspian_link_mux

---
 rtl/ucaspian_link_mux.sv | 166 ++++++++++++++++
 tb/tb_ucaspian_link_mux.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucaspian_link_mux.sv
`default_nettype none
// ============================================================================
// Module   : ucaspian_link_mux
// Brief    : Packet-atomic round-robin merge of NUM_CH byte channels onto one
//            host TX byte link, with optional channel-tag header byte.
// Revision : 1.0 - initial release
// ============================================================================
module ucaspian_link_mux #(
   parameter int         NUM_CH   = 4,
   parameter bit         TAG_EN   = 1'b1,
   parameter logic [7:0] TAG_BASE = 8'hF0,
   parameter int         MAX_LEN  = 16
) (
   input  logic                  sys_clk,
   input  logic                  reset,
   input  logic [NUM_CH*8-1:0]   ch_data,
   input  logic [NUM_CH-1:0]     ch_vld,
   input  logic [NUM_CH-1:0]     ch_last,
   output logic [NUM_CH-1:0]     ch_rdy,
   output logic [7:0]            write_data,
   output logic                  write_vld,
   input  logic                  write_rdy,
   output logic [3:0]            grant_ch,
   output logic                  busy,
   output logic [NUM_CH-1:0]     len_err,
   input  logic                  err_clr
);

   localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CH_W:0]    NUM_CH_V  = (CH_W+1)'(NUM_CH);
   localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
   localparam logic [7:0]       LAST_IDX  = 8'(MAX_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t              r_state;
   logic [CH_W-1:0]     r_grant;
   logic [CH_W-1:0]     r_rr_ptr;
   logic [7:0]          r_cnt;
   logic [NUM_CH-1:0]   r_len_err;
   logic                r_busy;

   logic [7:0]          w_bytes [NUM_CH];
   logic [2*NUM_CH-1:0] w_rot;
   logic [CH_W-1:0]     w_off;
   logic [CH_W:0]       w_sum;
   logic [CH_W-1:0]     w_pick;
   logic [CH_W-1:0]     w_rr_nxt;
   logic                w_any;
   logic                w_accept;
   logic                w_last;
   logic                w_at_max;
   logic                w_end;
   logic [NUM_CH-1:0]   w_trunc_set;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
         assign w_bytes[g] = ch_data[8*g +: 8];
      end
   endgenerate

   // Rotate requests so bit 0 is rr_ptr; lowest set bit is the winner offset.
   assign w_rot = {ch_vld, ch_vld} >> r_rr_ptr;
   assign w_any = |ch_vld;

   always_comb begin
      w_off = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = CH_W'(i);
         end
      end
   end

   assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_pick   = (w_sum >= NUM_CH_V) ? CH_W'(w_sum - NUM_CH_V) : CH_W'(w_sum);
   assign w_rr_nxt = (r_grant == LAST_CH) ? '0 : r_grant + CH_W'(1);

   assign w_accept = (r_state == S_DATA) && ch_vld[r_grant] && write_rdy;
   assign w_last   = ch_last[r_grant];
   assign w_at_max = (r_cnt == LAST_IDX);
   assign w_end    = w_accept && (w_last || w_at_max);

   always_comb begin
      w_trunc_set = '0;
      if (w_accept && !w_last && w_at_max) begin
         w_trunc_set[r_grant] = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_rr_ptr  <= '0;
         r_cnt     <= '0;
         r_len_err <= '0;
         r_busy    <= 1'b0;
      end else begin
         // A new truncation wins over a coincident clear for its own bit.
         r_len_err <= (r_len_err & ~{NUM_CH{err_clr}}) | w_trunc_set;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= TAG_EN ? S_HDR : S_DATA;
               end
            end
            S_HDR: begin
               if (write_rdy) begin
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + 8'd1;
                  if (w_end) begin
                     r_state  <= S_IDLE;
                     r_busy   <= 1'b0;
                     r_rr_ptr <= w_rr_nxt;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      grant_ch             = '0;
      grant_ch[CH_W-1:0]   = r_grant;
   end

   // Payload path is a direct pass-through of the granted channel.
   always_comb begin
      write_vld  = 1'b0;
      write_data = 8'h00;
      ch_rdy     = '0;
      case (r_state)
         S_HDR: begin
            write_vld  = 1'b1;
            write_data = TAG_BASE | {4'h0, grant_ch};
         end
         S_DATA: begin
            write_vld        = ch_vld[r_grant];
            write_data       = w_bytes[r_grant];
            ch_rdy[r_grant]  = write_rdy;
         end
         default: ;
      endcase
   end

   assign busy    = r_busy;
   assign len_err = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_ucaspian_link_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucaspian_link_mux
// Brief    : Directed vector table, stream sequences and randomized scoreboard
//            for ucaspian_link_mux (NUM_CH=4, TAG_EN=1, MAX_LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucaspian_link_mux;

   localparam int NCH  = 4;
   localparam int MAXL = 4;

   logic        sys_clk = 1'b0;
   logic        reset   = 1'b1;
   logic [31:0] ch_data = '0;
   logic [3:0]  ch_vld  = '0;
   logic [3:0]  ch_last = '0;
   logic [3:0]  ch_rdy;
   logic [7:0]  write_data;
   logic        write_vld;
   logic        write_rdy = 1'b0;
   logic [3:0]  grant_ch;
   logic        busy;
   logic [3:0]  len_err;
   logic        err_clr = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   ucaspian_link_mux #(.NUM_CH(NCH), .TAG_EN(1'b1), .TAG_BASE(8'hF0), .MAX_LEN(MAXL)) dut (
      .sys_clk(sys_clk), .reset(reset), .ch_data(ch_data), .ch_vld(ch_vld),
      .ch_last(ch_last), .ch_rdy(ch_rdy), .write_data(write_data),
      .write_vld(write_vld), .write_rdy(write_rdy), .grant_ch(grant_ch),
      .busy(busy), .len_err(len_err), .err_clr(err_clr)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  last;
      logic [31:0] data;
      logic        wr;
      logic        clr;
      logic        ev;
      logic [7:0]  ed;
      logic [3:0]  erdy;
      logic        eb;
      logic [3:0]  eg;
      logic [3:0]  elen;
   } vec_t;

   vec_t vecs[$];

   // Upstream sources (q_*), scoreboard expectations (e_*) and captured TX bytes
   logic [7:0] q_d [NCH][$];
   bit         q_l [NCH][$];
   logic [7:0] e_d [NCH][$];
   bit         e_l [NCH][$];
   logic [7:0] cap [$];
   logic [7:0] exp_s [$];
   bit         rand_mode = 1'b0;

   int         m_rr, m_phase, m_ch, m_cnt;
   logic [3:0] m_len;

   function automatic vec_t v(logic [3:0] vld, logic [3:0] last, logic [31:0] data,
                              logic wr, logic clr, logic ev, logic [7:0] ed,
                              logic [3:0] erdy, logic eb, logic [3:0] eg, logic [3:0] elen);
      vec_t r;
      r.vld = vld; r.last = last; r.data = data; r.wr = wr; r.clr = clr;
      r.ev = ev; r.ed = ed; r.erdy = erdy; r.eb = eb; r.eg = eg; r.elen = elen;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int rr_pick(logic [3:0] vld, int rr);
      for (int k = 0; k < NCH; k++) begin
         if (vld[(rr + k) % NCH]) return (rr + k) % NCH;
      end
      return -1;
   endfunction

   task automatic push_b(input int c, input logic [7:0] b, input bit l);
      q_d[c].push_back(b);
      q_l[c].push_back(l);
   endtask

   task automatic add_pkt(input int c, input int len);
      logic [7:0] b;
      for (int k = 0; k < len; k++) begin
         b = 8'($urandom);
         push_b(c, b, k == len - 1);
         e_d[c].push_back(b);
         e_l[c].push_back(k == len - 1);
      end
   endtask

   task automatic clear_all();
      for (int c = 0; c < NCH; c++) begin
         q_d[c].delete(); q_l[c].delete(); e_d[c].delete(); e_l[c].delete();
      end
      cap.delete();
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      reset = 1'b1; ch_vld = '0; write_rdy = 1'b0; err_clr = 1'b0;
      @(negedge sys_clk);
      reset = 1'b0;
      clear_all();
   endtask

   task automatic model_step();
      logic [3:0] nlen;
      int         p;
      logic [7:0] eb;
      bit         el;
      nlen = err_clr ? 4'h0 : m_len;
      chk("rnd len_err", len_err, m_len);
      chk("rnd busy", busy, m_phase != 0);
      case (m_phase)
         0: begin
            chk("rnd idle wvld", write_vld, 0);
            chk("rnd idle rdy", ch_rdy, 0);
            p = rr_pick(ch_vld, m_rr);
            if (p >= 0) begin m_ch = p; m_phase = 1; end
         end
         1: begin
            chk("rnd hdr wvld", write_vld, 1);
            chk("rnd hdr data", write_data, 8'hF0 | 8'(m_ch));
            chk("rnd hdr grant", grant_ch, m_ch);
            chk("rnd hdr rdy", ch_rdy, 0);
            if (write_rdy) begin m_phase = 2; m_cnt = 0; end
         end
         default: begin
            chk("rnd data grant", grant_ch, m_ch);
            chk("rnd data wvld", write_vld, ch_vld[m_ch]);
            chk("rnd data rdy", ch_rdy, write_rdy ? (4'b1 << m_ch) : 4'b0);
            if (write_vld && write_rdy) begin
               chk("rnd payload avail", e_d[m_ch].size() > 0, 1);
               if (e_d[m_ch].size() > 0) begin
                  eb = e_d[m_ch].pop_front();
                  el = e_l[m_ch].pop_front();
                  chk("rnd payload", write_data, eb);
                  m_cnt++;
                  if (el || m_cnt == MAXL) begin
                     if (!el) nlen[m_ch] = 1'b1;
                     m_rr    = (m_ch + 1) % NCH;
                     m_phase = 0;
                  end
               end
            end
         end
      endcase
      m_len = nlen;
   endtask

   task automatic cycle(input bit do_model);
      bit en;
      @(negedge sys_clk);
      for (int c = 0; c < NCH; c++) begin
         en = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (q_d[c].size() > 0) begin
            ch_vld[c] = en; ch_data[c*8 +: 8] = q_d[c][0]; ch_last[c] = q_l[c][0];
         end else begin
            ch_vld[c] = 1'b0; ch_data[c*8 +: 8] = 8'($urandom); ch_last[c] = 1'b0;
         end
      end
      write_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      err_clr   = rand_mode ? ($urandom_range(0, 15) == 0) : 1'b0;
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (ch_vld[c] && ch_rdy[c]) begin
            void'(q_d[c].pop_front());
            void'(q_l[c].pop_front());
         end
      end
      if (write_vld && write_rdy) cap.push_back(write_data);
      if (do_model) model_step();
   endtask

   task automatic chk_stream(input string name, input bit exact);
      chk({name, " count"}, exact ? (cap.size() == exp_s.size()) : (cap.size() >= exp_s.size()), 1);
      for (int i = 0; i < exp_s.size(); i++) begin
         if (i < cap.size()) chk($sformatf("%s byte%0d", name, i), cap[i], exp_s[i]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  done;
      bool_loop: begin end
      // Reset state observed while reset is held
      repeat (2) @(negedge sys_clk);
      #1;
      chk("reset wvld", write_vld, 0);
      chk("reset busy", busy, 0);
      chk("reset rdy", ch_rdy, 0);
      chk("reset grant", grant_ch, 0);
      chk("reset len_err", len_err, 0);
      @(negedge sys_clk);
      reset = 1'b0;

      // Three-byte packet on ch2
      vecs.push_back(v(4'b0100, 4'b0000, 32'h0011_0000, 1, 0, 0, 8'h00, 4'b0000, 0, 0, 0));
      vecs.push_back(v(4'b0100, 4'b0000, 32'h0011_0000, 1, 0, 1, 8'hF2, 4'b0000, 1, 2, 0));
      vecs.push_back(v(4'b0100, 4'b0000, 32'h0011_0000, 1, 0, 1, 8'h11, 4'b0100, 1, 2, 0));
      vecs.push_back(v(4'b0100, 4'b0000, 32'h0022_0000, 1, 0, 1, 8'h22, 4'b0100, 1, 2, 0));
      vecs.push_back(v(4'b0100, 4'b0100, 32'h0033_0000, 1, 0, 1, 8'h33, 4'b0100, 1, 2, 0));
      vecs.push_back(v(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 4'b0000, 0, 2, 0));
      // ch0 six bytes with MAX_LEN=4: truncation, then remainder, then clear
      vecs.push_back(v(4'b0001, 4'b0000, 32'h0000_00A1, 1, 0, 0, 8'h00, 4'b0000, 0, 2, 0));
      vecs.push_back(v(4'b0001, 4'b0000, 32'h0000_00A1, 1, 0, 1, 8'hF0, 4'b0000, 1, 0, 0));
      vecs.push_back(v(4'b0001, 4'b0000, 32'h0000_00A1, 1, 0, 1, 8'hA1, 4'b0001, 1, 0, 0));
      vecs.push_back(v(4'b0001, 4'b0000, 32'h0000_00A2, 1, 0, 1, 8'hA2, 4'b0001, 1, 0, 0));
      vecs.push_back(v(4'b0001, 4'b0000, 32'h0000_00A3, 1, 0, 1, 8'hA3, 4'b0001, 1, 0, 0));
      vecs.push_back(v(4'b0001, 4'b0000, 32'h0000_00A4, 1, 0, 1, 8'hA4, 4'b0001, 1, 0, 0));
      vecs.push_back(v(4'b0001, 4'b0000, 32'h0000_00A5, 1, 0, 0, 8'h00, 4'b0000, 0, 0, 4'b0001));
      vecs.push_back(v(4'b0001, 4'b0000, 32'h0000_00A5, 1, 0, 1, 8'hF0, 4'b0000, 1, 0, 4'b0001));
      vecs.push_back(v(4'b0001, 4'b0000, 32'h0000_00A5, 1, 0, 1, 8'hA5, 4'b0001, 1, 0, 4'b0001));
      vecs.push_back(v(4'b0001, 4'b0001, 32'h0000_00A6, 1, 0, 1, 8'hA6, 4'b0001, 1, 0, 4'b0001));
      vecs.push_back(v(4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 0, 8'h00, 4'b0000, 0, 0, 4'b0001));
      vecs.push_back(v(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 4'b0000, 0, 0, 4'b0000));
      // ch1 with five-cycle write_rdy stalls in both header and payload
      vecs.push_back(v(4'b0010, 4'b0000, 32'h0000_5A00, 0, 0, 0, 8'h00, 4'b0000, 0, 0, 0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(v(4'b0010, 4'b0000, 32'h0000_5A00, 0, 0, 1, 8'hF1, 4'b0000, 1, 1, 0));
      vecs.push_back(v(4'b0010, 4'b0000, 32'h0000_5A00, 1, 0, 1, 8'hF1, 4'b0000, 1, 1, 0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(v(4'b0010, 4'b0000, 32'h0000_5A00, 0, 0, 1, 8'h5A, 4'b0000, 1, 1, 0));
      vecs.push_back(v(4'b0010, 4'b0000, 32'h0000_5A00, 1, 0, 1, 8'h5A, 4'b0010, 1, 1, 0));
      vecs.push_back(v(4'b0010, 4'b0010, 32'h0000_5B00, 1, 0, 1, 8'h5B, 4'b0010, 1, 1, 0));
      vecs.push_back(v(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 4'b0000, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge sys_clk);
         ch_vld = vecs[i].vld; ch_last = vecs[i].last; ch_data = vecs[i].data;
         write_rdy = vecs[i].wr; err_clr = vecs[i].clr;
         #1;
         chk($sformatf("vec%0d wvld", i), write_vld, vecs[i].ev);
         chk($sformatf("vec%0d wdata", i), write_data, vecs[i].ed);
         chk($sformatf("vec%0d ch_rdy", i), ch_rdy, vecs[i].erdy);
         chk($sformatf("vec%0d busy", i), busy, vecs[i].eb);
         chk($sformatf("vec%0d grant", i), grant_ch, vecs[i].eg);
         chk($sformatf("vec%0d len_err", i), len_err, vecs[i].elen);
      end

      // All channels streaming 1-byte packets: round-robin from channel 0
      do_reset();
      for (int c = 0; c < NCH; c++) begin
         push_b(c, 8'(8'hC0 + c), 1'b1);
         push_b(c, 8'(8'hC0 + c), 1'b1);
      end
      repeat (16) cycle(1'b0);
      exp_s = '{8'hF0, 8'hC0, 8'hF1, 8'hC1, 8'hF2, 8'hC2, 8'hF3, 8'hC3, 8'hF0, 8'hC0};
      chk_stream("rr4", 1'b0);

      // ch1 packet is not interrupted by ch0/ch3 requests; then ch3, then ch0
      do_reset();
      push_b(1, 8'h31, 1'b0); push_b(1, 8'h32, 1'b0); push_b(1, 8'h33, 1'b1);
      repeat (3) cycle(1'b0);
      push_b(0, 8'hA0, 1'b1);
      push_b(3, 8'hD0, 1'b1);
      repeat (12) cycle(1'b0);
      exp_s = '{8'hF1, 8'h31, 8'h32, 8'h33, 8'hF3, 8'hD0, 8'hF0, 8'hA0};
      chk_stream("atomic", 1'b1);

      // Reset in the middle of a ch1 payload, then re-grant with fresh header
      do_reset();
      push_b(1, 8'h71, 1'b0); push_b(1, 8'h72, 1'b0); push_b(1, 8'h73, 1'b1);
      repeat (3) cycle(1'b0);
      chk("midrst pre wvld", write_vld, 1);
      reset = 1'b1;
      #1;
      chk("midrst wvld", write_vld, 0);
      chk("midrst rdy", ch_rdy, 0);
      chk("midrst busy", busy, 0);
      chk("midrst grant", grant_ch, 0);
      @(negedge sys_clk);
      reset = 1'b0;
      cap.delete();
      repeat (8) cycle(1'b0);
      exp_s = '{8'hF1, 8'h72, 8'h73};
      chk_stream("midrst", 1'b1);

      // Randomized traffic against the scoreboard
      do_reset();
      m_rr = 0; m_phase = 0; m_ch = 0; m_cnt = 0; m_len = '0;
      rand_mode = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if (q_d[c].size() < 3 && $urandom_range(0, 3) == 0)
               add_pkt(c, $urandom_range(1, 6));
         end
         cycle(1'b1);
      end
      done = 0;
      for (int n = 0; n < 3000 && done == 0; n++) begin
         cycle(1'b1);
         done = 1;
         for (int c = 0; c < NCH; c++) if (q_d[c].size() != 0) done = 0;
         if (m_phase != 0) done = 0;
      end
      chk("rnd drain finished", done, 1);
      for (int c = 0; c < NCH; c++)
         chk($sformatf("rnd exp empty ch%0d", c), e_d[c].size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
